probe_sync_trig: RTL and testbench

PROBE_SYNC_TRIG -- requirements
Module: probe_sync_trig

---
 rtl/probe_pkg.sv | 19 +
 rtl/probe_sync_bit.sv | 24 ++
 rtl/probe_sync_trig.sv | 147 ++++++++++++++
 tb/tb_probe_sync_trig.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_pkg.sv
// Shared types for the probe synchronizer/trigger: FSM states, trigger modes, default bus width.
// Pure declarations: no latency, no flow control.
package probe_pkg;

    localparam int PROBE_W_DEFAULT = 21;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FIRED   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam logic [1:0] MODE_PATTERN = 2'd0;
    localparam logic [1:0] MODE_RISE    = 2'd1;
    localparam logic [1:0] MODE_FALL    = 2'd2;
    localparam logic [1:0] MODE_ANY     = 2'd3;

endpackage

// File: rtl/probe_sync_bit.sv
// Single-bit synchronizer chain, STAGES flops deep, for one asynchronous probe line.
// Latency STAGES cycles; always accepts input, no backpressure.
module probe_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic probe,
    output logic synced
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], probe};
        end
    end

    assign synced = chain[STAGES-1];

endmodule

// File: rtl/probe_sync_trig.sv
// Probe front end for the logic analyzer: synchronize, register, trigger FSM, decimation strobe.
// data_o lags probe_i by SYNC_STAGES+1 cycles with trig_o aligned to it; no backpressure.
module probe_sync_trig
    import probe_pkg::*;
#(
    parameter int PROBE_W     = PROBE_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_W      = 16,
    parameter int DECIM_W     = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic               arm_i,
    input  logic               disarm_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [4:0]         cfg_sel_i,
    input  logic [PROBE_W-1:0] cfg_mask_i,
    input  logic [PROBE_W-1:0] cfg_value_i,
    input  logic [HOLD_W-1:0]  cfg_holdoff_i,
    input  logic               cfg_rearm_i,
    input  logic [DECIM_W-1:0] cfg_decim_i,
    output logic [PROBE_W-1:0] data_o,
    output logic               trig_o,
    output logic               sample_en_o,
    output logic [1:0]         state_o
);

    localparam logic [DECIM_W-1:0] DECIM_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

    logic [PROBE_W-1:0] sync;
    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DECIM_W-1:0] decim_cnt;
    logic [DECIM_W-1:0] decim_nxt;
    logic               cur_bit;
    logic               prev_bit;
    logic               pat_now;
    logic               pat_prev;
    logic               cond;
    logic               fire;

    for (genvar i = 0; i < PROBE_W; i++) begin : g_sync
        probe_sync_bit #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk_i),
            .rst    (rst_i),
            .probe  (probe_i[i]),
            .synced (sync[i])
        );
    end

    // data_o holds the previous synchronized sample, so it doubles as the edge reference
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else begin
            data_o <= sync;
        end
    end

    // Out-of-range selects leave both bits at 0, so no edge can ever be seen
    always_comb begin
        cur_bit  = 1'b0;
        prev_bit = 1'b0;
        for (int i = 0; i < PROBE_W; i++) begin
            if (int'(cfg_sel_i) == i) begin
                cur_bit  = sync[i];
                prev_bit = data_o[i];
            end
        end
    end

    assign pat_now  = ((sync & cfg_mask_i) == (cfg_value_i & cfg_mask_i));
    assign pat_prev = ((data_o & cfg_mask_i) == (cfg_value_i & cfg_mask_i));

    always_comb begin
        cond = 1'b0;
        case (cfg_mode_i)
            MODE_PATTERN: cond = pat_now && !pat_prev;
            MODE_RISE:    cond = cur_bit && !prev_bit;
            MODE_FALL:    cond = !cur_bit && prev_bit;
            MODE_ANY:     cond = cur_bit != prev_bit;
            default:      cond = 1'b0;
        endcase
    end

    assign fire = (state == ST_ARMED) && cond && !disarm_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            trig_o   <= 1'b0;
        end else begin
            trig_o <= fire;
            if (disarm_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm_i) state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (cond) state <= ST_FIRED;
                    end
                    ST_FIRED: begin
                        state    <= ST_HOLDOFF;
                        hold_cnt <= cfg_holdoff_i;
                    end
                    ST_HOLDOFF: begin
                        if (hold_cnt == '0) begin
                            state <= cfg_rearm_i ? ST_ARMED : ST_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_ONE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign state_o = state;

    // >= rather than == so a shrunken period still wraps instead of running to overflow
    always_comb begin
        if (fire || (decim_cnt >= cfg_decim_i)) begin
            decim_nxt = '0;
        end else begin
            decim_nxt = decim_cnt + DECIM_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            decim_cnt   <= '0;
            sample_en_o <= 1'b0;
        end else begin
            decim_cnt   <= decim_nxt;
            sample_en_o <= (decim_nxt == '0);
        end
    end

endmodule

// File: tb/tb_probe_sync_trig.sv
// Bench for probe_sync_trig: directed scenarios plus randomized traffic against a cycle-arithmetic model.
module tb_probe_sync_trig;

    localparam int PW = 21;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] probe;
    logic          arm;
    logic          disarm;
    logic [1:0]    cfg_mode;
    logic [4:0]    cfg_sel;
    logic [PW-1:0] cfg_mask;
    logic [PW-1:0] cfg_value;
    logic [15:0]   cfg_holdoff;
    logic          cfg_rearm;
    logic [7:0]    cfg_decim;
    logic [PW-1:0] data_o;
    logic          trig_o;
    logic          sample_en_o;
    logic [1:0]    state_o;

    probe_sync_trig #(
        .PROBE_W     (PW),
        .SYNC_STAGES (S),
        .HOLD_W      (16),
        .DECIM_W     (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .probe_i       (probe),
        .arm_i         (arm),
        .disarm_i      (disarm),
        .cfg_mode_i    (cfg_mode),
        .cfg_sel_i     (cfg_sel),
        .cfg_mask_i    (cfg_mask),
        .cfg_value_i   (cfg_value),
        .cfg_holdoff_i (cfg_holdoff),
        .cfg_rearm_i   (cfg_rearm),
        .cfg_decim_i   (cfg_decim),
        .data_o        (data_o),
        .trig_o        (trig_o),
        .sample_en_o   (sample_en_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ntrig = 0;
    int last_trig = -1;
    logic trig_d2 = 1'b0;

    // Reference model: probe history queue, a coarse phase (idle/armed/episode) and cycle arithmetic
    logic [PW-1:0] hist[$];
    int  m_phase = 0;
    int  t_trig = 0;
    int  m_hold = 0;
    int  anchor = 0;
    logic [PW-1:0] m_data = '0;
    logic m_trig = 1'b0;
    logic m_se = 1'b0;
    logic [1:0] m_state = 2'd0;

    function automatic bit mode_hit(input logic [PW-1:0] cur, input logic [PW-1:0] prev);
        int s = int'(cfg_sel);
        bit c, p;
        if (cfg_mode == 2'd0)
            return ((cur & cfg_mask) == (cfg_value & cfg_mask)) && !((prev & cfg_mask) == (cfg_value & cfg_mask));
        if (s >= PW) return 1'b0;
        c = cur[s];
        p = prev[s];
        if (cfg_mode == 2'd1) return c && !p;
        if (cfg_mode == 2'd2) return !c && p;
        return c != p;
    endfunction

    task automatic model_edge();
        logic [PW-1:0] cur, prev;
        if (rst) begin
            hist.delete();
            repeat (S + 2) hist.push_back('0);
            m_phase = 0;
            anchor  = cyc;
            m_data  = '0;
            m_trig  = 1'b0;
            m_se    = 1'b0;
            m_state = 2'd0;
            return;
        end
        hist.push_back(probe);
        if (hist.size() > 12) void'(hist.pop_front());
        cur  = hist[hist.size() - 1 - S];
        prev = hist[hist.size() - 2 - S];
        m_trig = 1'b0;
        if (disarm) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (arm) m_phase = 1;
        end else if (m_phase == 1) begin
            if (mode_hit(cur, prev)) begin
                m_trig  = 1'b1;
                t_trig  = cyc;
                m_hold  = int'(cfg_holdoff);
                anchor  = cyc;
                m_phase = 2;
            end
        end else if (cyc - t_trig == m_hold + 2) begin
            m_phase = cfg_rearm ? 1 : 0;
        end
        m_data  = cur;
        m_state = (m_phase == 2) ? ((cyc == t_trig) ? 2'd2 : 2'd3) : 2'(m_phase);
        m_se    = ((cyc - anchor) % (int'(cfg_decim) + 1)) == 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("data", 32'(data_o), 32'(m_data));
        check("trig", 32'(trig_o), 32'(m_trig));
        check("sample_en", 32'(sample_en_o), 32'(m_se));
        check("state", 32'(state_o), 32'(m_state));
        if (trig_o) begin
            ntrig++;
            last_trig = cyc;
            trig_d2 = data_o[2];
            check("se_at_trig", 32'(sample_en_o), 32'd1);
        end
    endtask

    task automatic drive_bit2(input bit b);
        probe = PW'($urandom);
        probe[2] = b;
    endtask

    task automatic drive_low2(input logic [1:0] lo);
        probe = PW'($urandom);
        probe[1:0] = lo;
    endtask

    task automatic arm_rise(input int hold, input bit rearm);
        disarm = 1'b1; drive_bit2(1'b0); step(); disarm = 1'b0;
        cfg_mode = 2'd1; cfg_sel = 5'd2; cfg_holdoff = 16'(hold); cfg_rearm = rearm;
        repeat (3) begin drive_bit2(1'b0); step(); end
        arm = 1'b1; drive_bit2(1'b0); step(); arm = 1'b0;
        repeat (3) begin drive_bit2(1'b0); step(); end
    endtask

    initial begin
        int e, t, n0;
        rst = 1'b1; arm = 1'b0; disarm = 1'b0; probe = '0;
        cfg_mode = 2'd1; cfg_sel = 5'd2; cfg_mask = '0; cfg_value = '0;
        cfg_holdoff = 16'd2; cfg_rearm = 1'b0; cfg_decim = 8'd3;
        repeat (3) step();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        rst = 1'b0;

        // Single rising edge on bit 2: one pulse, two edges after the probe is sampled
        arm_rise(2, 1'b0);
        n0 = ntrig; e = cyc + 1;
        repeat (8) begin drive_bit2(1'b1); step(); end
        check("rise_count", 32'(ntrig - n0), 32'd1);
        check("rise_latency", 32'(last_trig - e), 32'd2);
        check("rise_data2", 32'(trig_d2), 32'd1);

        // Sustained pattern match with auto-rearm fires only once
        disarm = 1'b1; step(); disarm = 1'b0;
        cfg_mode = 2'd0; cfg_mask = 21'h3; cfg_value = 21'h2; cfg_rearm = 1'b1; cfg_holdoff = 16'd0;
        repeat (3) begin drive_low2(2'd0); step(); end
        arm = 1'b1; drive_low2(2'd0); step(); arm = 1'b0;
        repeat (3) begin drive_low2(2'd0); step(); end
        n0 = ntrig;
        repeat (13) begin drive_low2(2'd2); step(); end
        check("pattern_count", 32'(ntrig - n0), 32'd1);

        // Holdoff 5 with rearm: edge inside holdoff ignored, later edge fires
        arm_rise(5, 1'b1);
        n0 = ntrig;
        repeat (3) begin drive_bit2(1'b1); step(); end
        t = cyc;
        check("ho_first", 32'(last_trig), 32'(t));
        for (int k = 1; k <= 20; k++) begin
            drive_bit2((k >= 3 && k < 6) || k >= 12);
            step();
        end
        check("ho_count", 32'(ntrig - n0), 32'd2);
        check("ho_second", 32'(last_trig - t), 32'd14);

        // Disarm coinciding with the edge condition wins
        arm_rise(2, 1'b0);
        n0 = ntrig; e = cyc + 1;
        for (int k = 0; k < 7; k++) begin
            drive_bit2(1'b1);
            disarm = (k == 2);
            step();
        end
        disarm = 1'b0;
        check("disarm_count", 32'(ntrig - n0), 32'd0);
        check("disarm_state", 32'(state_o), 32'd0);

        // Reset in the middle of a long holdoff
        arm_rise(20, 1'b0);
        repeat (3) begin drive_bit2(1'b1); step(); end
        repeat (14) begin drive_bit2(1'b1); step(); end
        check("mid_holdoff_state", 32'(state_o), 32'd3);
        rst = 1'b1; step(); rst = 1'b0;
        check("post_rst_state", 32'(state_o), 32'd0);
        check("post_rst_trig", 32'(trig_o), 32'd0);
        check("post_rst_se", 32'(sample_en_o), 32'd0);
        check("post_rst_data", 32'(data_o), 32'd0);
        n0 = ntrig;
        for (int k = 0; k < 10; k++) begin drive_bit2(k[0]); step(); end
        check("no_trig_unarmed", 32'(ntrig - n0), 32'd0);
        arm = 1'b1; drive_bit2(1'b0); step(); arm = 1'b0;
        for (int k = 0; k < 8; k++) begin drive_bit2(k >= 2); step(); end
        check("rearmed_count", 32'(ntrig - n0), 32'd1);

        // Decimation 0 holds the strobe high
        rst = 1'b1; cfg_decim = 8'd0; step(); rst = 1'b0;
        repeat (6) begin
            probe = PW'($urandom);
            step();
            check("decim0_se", 32'(sample_en_o), 32'd1);
        end

        // Randomized blocks: config changes only across a reset
        for (int b = 0; b < 24; b++) begin
            rst = 1'b1;
            cfg_decim   = 8'($urandom_range(0, 5));
            cfg_mode    = 2'($urandom_range(0, 3));
            cfg_sel     = 5'($urandom_range(0, 23));
            cfg_mask    = PW'($urandom) & 21'h7;
            cfg_value   = PW'($urandom);
            cfg_holdoff = 16'($urandom_range(0, 6));
            cfg_rearm   = 1'($urandom_range(0, 1));
            step();
            rst = 1'b0;
            repeat (60) begin
                probe  = PW'($urandom);
                arm    = ($urandom_range(0, 9) == 0);
                disarm = ($urandom_range(0, 29) == 0);
                step();
            end
            arm = 1'b0; disarm = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
